// File: rtl/alu_serial_exec_if.sv
// Request/response bundle for the slice-serial ALU.
// Handshake: start is accepted only while busy=0; done pulses for one cycle with result/zero/illegalOp valid.
interface alu_serial_exec_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       aluCtrl;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegalOp;

    modport master (
        output start, aluCtrl, operandA, operandB,
        input  busy, done, result, zero, illegalOp
    );

    modport slave (
        input  start, aluCtrl, operandA, operandB,
        output busy, done, result, zero, illegalOp
    );
endinterface

// File: rtl/alu_serial_exec.sv
// Slice-serial add/sub/and/or unit: SLICE bits per cycle, LSB slice first, start/busy/done handshake.
module alu_serial_exec #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic               clk,
    input  logic               reset,
    alu_serial_exec_if.slave   bus,
    output logic [1:0]         dbg_state_o
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             zero_q, zero_d, ill_q, ill_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_b_eff, sl_res;
    logic [SLICE:0]   sl_sum;
    logic             legal;
    logic             last_slice;

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                sl_a = a_q[i*SLICE +: SLICE];
                sl_b = b_q[i*SLICE +: SLICE];
            end
        end
        legal      = (ctrl_q == OP_AND) || (ctrl_q == OP_OR) ||
                     (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB);
        sl_b_eff   = (ctrl_q == OP_SUB) ? ~sl_b : sl_b;
        sl_sum     = {1'b0, sl_a} + {1'b0, sl_b_eff} + {{SLICE{1'b0}}, carry_q};
        last_slice = (cnt_q == CW'(N - 1));
        case (ctrl_q)
            OP_ADD, OP_SUB: sl_res = sl_sum[SLICE-1:0];
            OP_AND:         sl_res = sl_a & sl_b;
            OP_OR:          sl_res = sl_a | sl_b;
            default:        sl_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.operandA;
                    b_d     = bus.operandB;
                    ctrl_d  = bus.aluCtrl;
                    cnt_d   = '0;
                    carry_d = (bus.aluCtrl == OP_SUB);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_q == CW'(i)) res_d[i*SLICE +: SLICE] = sl_res;
                end
                carry_d = sl_sum[SLICE];
                cnt_d   = cnt_q + CW'(1);
                if (last_slice) begin
                    // Flags are taken from the fully assembled result, including this last slice.
                    zero_d  = (res_d == '0);
                    ill_d   = !legal;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.illegalOp = ill_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_alu_serial_exec.sv
// Randomized scoreboard bench for alu_serial_exec with a plain-arithmetic reference model.
module tb_alu_serial_exec;
    localparam int W = 32;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    alu_serial_exec_if #(.WIDTH(W)) bus ();

    alu_serial_exec #(.WIDTH(W), .SLICE(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W+1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: {illegalOp, zero, result}
    function automatic logic [W+1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         ill;
        ill = 1'b0;
        case (c)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            default: begin r = '0; ill = 1'b1; end
        endcase
        return {ill, (r == '0), r};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("result", {32'd0, bus.result}, {32'd0, e[W-1:0]});
                chk("zero", {63'd0, bus.zero}, {63'd0, e[W]});
                chk("illegalOp", {63'd0, bus.illegalOp}, {63'd0, e[W+1]});
            end
        end
    end

    // driver: issue one op, check busy and done latency, optionally poke start mid-RUN
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W+1:0] e, input bit mid);
        int lat;
        int waitc;
        @(negedge clk);
        waitc = 0;
        while (bus.busy && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        bus.start    = 1'b1;
        bus.aluCtrl  = c;
        bus.operandA = a;
        bus.operandB = b;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.operandA = $urandom;
        bus.operandB = $urandom;
        bus.aluCtrl  = 4'($urandom);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (mid && k == 2) begin
                bus.start    = 1'b1;
                bus.operandA = $urandom;
                bus.operandB = $urandom;
                bus.aluCtrl  = 4'b0001;
            end
            if (mid && k == 3) bus.start = 1'b0;
            chk("busy_in_op", {63'd0, bus.busy}, 64'd1);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("done_latency", 64'(lat), 64'd5);
        @(negedge clk);
        chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int t1, t2;
        logic [3:0]   c;
        logic [W-1:0] a, b;
        bus.start    = 1'b0;
        bus.aluCtrl  = 4'b0;
        bus.operandA = '0;
        bus.operandB = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_zero", {63'd0, bus.zero}, 64'd0);
        chk("rst_illegal", {63'd0, bus.illegalOp}, 64'd0);
        chk("rst_state", {62'd0, dbg_state}, 64'd0);
        reset = 1'b0;

        // directed cases with hand-derived expectations
        run_op(4'b0010, 32'd5, 32'd7, {2'b00, 32'h0000000C}, 1'b0);
        run_op(4'b0110, 32'd0, 32'd1, {2'b00, 32'hFFFFFFFF}, 1'b0);
        run_op(4'b0110, 32'h12345678, 32'h12345678, {2'b01, 32'h0}, 1'b0);
        run_op(4'b0000, 32'hF0F0FF00, 32'hFF00F0F0, {2'b00, 32'hF000F000}, 1'b0);
        run_op(4'b0001, 32'hF0F0FF00, 32'hFF00F0F0, {2'b00, 32'hFFF0FFF0}, 1'b0);
        run_op(4'b0111, 32'd3, 32'd4, {2'b11, 32'h0}, 1'b0);
        run_op(4'b0010, 32'h000000FF, 32'h00000001, {2'b00, 32'h00000100}, 1'b1);

        // reset in the 2nd RUN cycle abandons the op
        @(negedge clk);
        bus.start = 1'b1; bus.aluCtrl = 4'b0010; bus.operandA = 32'd9; bus.operandB = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_result", {32'd0, bus.result}, 64'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        run_op(4'b0010, 32'd1, 32'd1, {2'b00, 32'd2}, 1'b0);

        // start held high: back-to-back ops every N+2 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.aluCtrl = 4'b0110; bus.operandA = 32'd100; bus.operandB = 32'd58;
        exp_q.push_back({2'b00, 32'd42});
        exp_q.push_back({2'b00, 32'd42});
        t1 = 0; t2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (t1 == 0) t1 = k;
                else begin
                    t2 = k;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b_first", 64'(t1), 64'd5);
        chk("b2b_spacing", 64'(t2 - t1), 64'd6);
        repeat (3) @(negedge clk);

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: c = 4'b0010;
                1: c = 4'b0110;
                2: c = 4'b0000;
                3: c = 4'b0001;
                default: c = 4'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            run_op(c, a, b, model(c, a, b), ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
